// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared select encodings for the forwarding and write-back muxes, used by
// the hazard controller and the datapath alike.
package fwd_hazard_ctrl_pkg;

    localparam int unsigned SEL_W = 2;

    // Operand forwarding selects
    localparam logic [SEL_W-1:0] FWD_NONE = 2'b00;
    localparam logic [SEL_W-1:0] FWD_EX   = 2'b01;
    localparam logic [SEL_W-1:0] FWD_MEM  = 2'b10;

    // Write-back source selects
    localparam logic [SEL_W-1:0] WB_ALU   = 2'b00;
    localparam logic [SEL_W-1:0] WB_DMEM  = 2'b01;
    localparam logic [SEL_W-1:0] WB_PC4   = 2'b10;

    // A producer whose result only exists after the data-memory access
    function automatic logic is_load(input logic [SEL_W-1:0] wb_sel);
        return wb_sel == WB_DMEM;
    endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// One pipeline-stage entry of the hazard tracker: load, bubble insert and
// synchronous reset; reset wins over a bubble, a bubble wins over a load.
module fwd_stage_reg
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  bubble,
    input  logic                  d_valid,
    input  logic                  d_wr_en,
    input  logic [REG_ADDR_W-1:0] d_wr_reg,
    input  logic [SEL_W-1:0]      d_wb_sel,
    input  logic [REG_ADDR_W-1:0] d_rs,
    input  logic [REG_ADDR_W-1:0] d_rt,
    input  logic                  d_use_rs,
    input  logic                  d_use_rt,
    output logic                  q_valid,
    output logic                  q_wr_en,
    output logic [REG_ADDR_W-1:0] q_wr_reg,
    output logic [SEL_W-1:0]      q_wb_sel,
    output logic [REG_ADDR_W-1:0] q_rs,
    output logic [REG_ADDR_W-1:0] q_rt,
    output logic                  q_use_rs,
    output logic                  q_use_rt
);

    always_ff @(posedge clk) begin
        if (rst || (load && bubble)) begin
            q_valid  <= 1'b0;
            q_wr_en  <= 1'b0;
            q_wr_reg <= '0;
            q_wb_sel <= WB_ALU;
            q_rs     <= '0;
            q_rt     <= '0;
            q_use_rs <= 1'b0;
            q_use_rt <= 1'b0;
        end else if (load) begin
            q_valid  <= d_valid;
            q_wr_en  <= d_wr_en;
            q_wr_reg <= d_wr_reg;
            q_wb_sel <= d_wb_sel;
            q_rs     <= d_rs;
            q_rt     <= d_rt;
            q_use_rs <= d_use_rs;
            q_use_rt <= d_use_rt;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control for a 5-stage pipeline.
// Define FWD_HAZARD_FORWARD_EN to enable operand forwarding; otherwise hazards stall.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic                  id_wr_en,
    input  logic [REG_ADDR_W-1:0] id_wr_reg,
    input  logic [SEL_W-1:0]      id_wb_sel,
    input  logic                  flush,
    output logic [SEL_W-1:0]      fwd_a_sel,
    output logic [SEL_W-1:0]      fwd_b_sel,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_cnt
);

    logic                  ex_valid,  mem_valid,  wb_valid;
    logic                  ex_wr_en,  mem_wr_en,  wb_wr_en;
    logic [REG_ADDR_W-1:0] ex_wr_reg, mem_wr_reg, wb_wr_reg;
    logic [SEL_W-1:0]      ex_wb_sel, mem_wb_sel, wb_wb_sel;
    logic [REG_ADDR_W-1:0] ex_rs,     mem_rs,     wb_rs;
    logic [REG_ADDR_W-1:0] ex_rt,     mem_rt,     wb_rt;
    logic                  ex_use_rs, mem_use_rs, wb_use_rs;
    logic                  ex_use_rt, mem_use_rt, wb_use_rt;
    logic                  ex_bubble;
    logic                  hazard;
    logic                  unused_fields;

    // Register $0 is hard-wired, so writes to it never produce a usable value
    function automatic logic hit(
        input logic                  valid,
        input logic                  wr_en,
        input logic [REG_ADDR_W-1:0] wr_reg,
        input logic [REG_ADDR_W-1:0] src
    );
        return valid && wr_en && (wr_reg == src) && (src != '0);
    endfunction

    assign ex_bubble = stall || flush;

    fwd_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_ex (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b1),
        .bubble   (ex_bubble),
        .d_valid  (id_valid),
        .d_wr_en  (id_wr_en),
        .d_wr_reg (id_wr_reg),
        .d_wb_sel (id_wb_sel),
        .d_rs     (id_rs),
        .d_rt     (id_rt),
        .d_use_rs (id_use_rs),
        .d_use_rt (id_use_rt),
        .q_valid  (ex_valid),
        .q_wr_en  (ex_wr_en),
        .q_wr_reg (ex_wr_reg),
        .q_wb_sel (ex_wb_sel),
        .q_rs     (ex_rs),
        .q_rt     (ex_rt),
        .q_use_rs (ex_use_rs),
        .q_use_rt (ex_use_rt)
    );

    fwd_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_mem (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b1),
        .bubble   (1'b0),
        .d_valid  (ex_valid),
        .d_wr_en  (ex_wr_en),
        .d_wr_reg (ex_wr_reg),
        .d_wb_sel (ex_wb_sel),
        .d_rs     (ex_rs),
        .d_rt     (ex_rt),
        .d_use_rs (ex_use_rs),
        .d_use_rt (ex_use_rt),
        .q_valid  (mem_valid),
        .q_wr_en  (mem_wr_en),
        .q_wr_reg (mem_wr_reg),
        .q_wb_sel (mem_wb_sel),
        .q_rs     (mem_rs),
        .q_rt     (mem_rt),
        .q_use_rs (mem_use_rs),
        .q_use_rt (mem_use_rt)
    );

    fwd_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_wb (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b1),
        .bubble   (1'b0),
        .d_valid  (mem_valid),
        .d_wr_en  (mem_wr_en),
        .d_wr_reg (mem_wr_reg),
        .d_wb_sel (mem_wb_sel),
        .d_rs     (mem_rs),
        .d_rt     (mem_rt),
        .d_use_rs (mem_use_rs),
        .d_use_rt (mem_use_rt),
        .q_valid  (wb_valid),
        .q_wr_en  (wb_wr_en),
        .q_wr_reg (wb_wr_reg),
        .q_wb_sel (wb_wb_sel),
        .q_rs     (wb_rs),
        .q_rt     (wb_rt),
        .q_use_rs (wb_use_rs),
        .q_use_rt (wb_use_rt)
    );

`ifdef FWD_HAZARD_FORWARD_EN
    // Only a load in EX cannot be forwarded in time; everything else is bypassed
    always_comb begin
        hazard = 1'b0;
        if (is_load(ex_wb_sel)) begin
            hazard = (id_use_rs && hit(ex_valid, ex_wr_en, ex_wr_reg, id_rs))
                  || (id_use_rt && hit(ex_valid, ex_wr_en, ex_wr_reg, id_rt));
        end
    end

    // MEM holds the newer result, so it wins over WB
    always_comb begin
        fwd_a_sel = FWD_NONE;
        fwd_b_sel = FWD_NONE;
        if (ex_valid && ex_use_rs) begin
            if (hit(mem_valid, mem_wr_en, mem_wr_reg, ex_rs)) begin
                fwd_a_sel = FWD_EX;
            end else if (hit(wb_valid, wb_wr_en, wb_wr_reg, ex_rs)) begin
                fwd_a_sel = FWD_MEM;
            end
        end
        if (ex_valid && ex_use_rt) begin
            if (hit(mem_valid, mem_wr_en, mem_wr_reg, ex_rt)) begin
                fwd_b_sel = FWD_EX;
            end else if (hit(wb_valid, wb_wr_en, wb_wr_reg, ex_rt)) begin
                fwd_b_sel = FWD_MEM;
            end
        end
    end

    assign unused_fields = ^{wb_wb_sel, wb_rs, wb_rt, wb_use_rs, wb_use_rt};
`else
    // No bypass: wait until the producer reaches WB (write-first register file)
    always_comb begin
        hazard = (id_use_rs && (hit(ex_valid, ex_wr_en, ex_wr_reg, id_rs)
                             || hit(mem_valid, mem_wr_en, mem_wr_reg, id_rs)))
              || (id_use_rt && (hit(ex_valid, ex_wr_en, ex_wr_reg, id_rt)
                             || hit(mem_valid, mem_wr_en, mem_wr_reg, id_rt)));
    end

    assign fwd_a_sel = FWD_NONE;
    assign fwd_b_sel = FWD_NONE;

    assign unused_fields = ^{wb_valid, wb_wr_en, wb_wr_reg, wb_wb_sel,
                             wb_rs, wb_rt, wb_use_rs, wb_use_rt};
`endif

    // A redirect squashes the ID instruction, so its hazard is moot
    assign stall = id_valid && hazard && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
